alu_op_driver: RTL

- Initiator side of the ALU operand/result interface.
- Accepts ALU commands (A, B, opcode) over a valid/ready command port and drives the registered ALU's operand and opcode inputs.
- Waits a fixed number of clocks for the ALU's registered result, captures result and flags, and returns them over a valid/ready response port.
- Rejects opcodes the ALU does not implement, and counts completed responses.

---
 rtl/alu_op_driver.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alu_op_driver.sv
// alu_op_driver: initiator side of a registered ALU.
// A command (A, B, opcode) comes in over a valid/ready port and is registered
// onto the ALU operand and opcode inputs. After a fixed wait the driver captures
// the ALU result and flags and returns them over a valid/ready response port.
// Opcodes the ALU does not implement get an immediate error response.
// A counter tracks how many responses have been handed off.
module alu_op_driver #(
    parameter int NUMBITS     = 8,
    parameter int ALU_LATENCY = 1,
    parameter int CNTBITS     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [NUMBITS-1:0] cmd_a,
    input  logic [NUMBITS-1:0] cmd_b,
    input  logic [2:0]         cmd_op,
    output logic [NUMBITS-1:0] alu_a,
    output logic [NUMBITS-1:0] alu_b,
    output logic [2:0]         alu_opcode,
    input  logic [NUMBITS-1:0] alu_result,
    input  logic               alu_carryout,
    input  logic               alu_overflow,
    input  logic               alu_zero,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [NUMBITS-1:0] rsp_result,
    output logic               rsp_carryout,
    output logic               rsp_overflow,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic [CNTBITS-1:0] op_count
);

    // The wait counter must be able to hold ALU_LATENCY itself.
    localparam int WAITBITS = $clog2(ALU_LATENCY + 1) + 1;
    localparam logic [WAITBITS-1:0] WAIT_LAST = WAITBITS'(ALU_LATENCY);
    localparam logic [WAITBITS-1:0] WAIT_ONE  = WAITBITS'(1);
    localparam logic [CNTBITS-1:0]  CNT_ONE   = CNTBITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WAITBITS-1:0] wait_cnt;
    logic                cmd_fire;
    logic                cmd_supported;
    logic                rsp_fire;
    logic                capture;

    // Opcodes implemented by the ALU: unsigned add, signed add, subtract, AND.
    function automatic logic op_supported(input logic [2:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            3'b000:  ok = 1'b1;
            3'b001:  ok = 1'b1;
            3'b010:  ok = 1'b1;
            3'b100:  ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Ready only in IDLE, and never while reset is held low.
    assign cmd_ready     = (state == ST_IDLE) & reset;
    assign cmd_fire      = cmd_valid & cmd_ready;
    assign cmd_supported = op_supported(cmd_op);
    assign rsp_fire      = rsp_valid & rsp_ready;

    // The last WAIT cycle: one extra cycle beyond ALU_LATENCY so the ALU has
    // sampled the new operands before its result is trusted.
    assign capture = (state == ST_WAIT) && (wait_cnt == WAIT_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one command in flight at a time.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_supported) begin
                        state_next = ST_WAIT;
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (capture) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_fire) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Wait counter: cleared on accept, counts each cycle spent in WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (cmd_fire) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + WAIT_ONE;
        end
    end

    // ALU operand/opcode registers: loaded only by a supported command and
    // held steady through WAIT and RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
        end else if (cmd_fire && cmd_supported) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_opcode <= cmd_op;
        end
    end

    // Response payload: loaded on the error edge or the capture edge only;
    // flags are passed through exactly as the ALU produced them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_result   <= '0;
            rsp_carryout <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_err      <= 1'b0;
        end else if (cmd_fire && !cmd_supported) begin
            rsp_result   <= '0;
            rsp_carryout <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_err      <= 1'b1;
        end else if (capture) begin
            rsp_result   <= alu_result;
            rsp_carryout <= alu_carryout;
            rsp_overflow <= alu_overflow;
            rsp_zero     <= alu_zero;
            rsp_err      <= 1'b0;
        end
    end

    // Response valid: raised when a payload is loaded, dropped on handoff.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
        end else if ((cmd_fire && !cmd_supported) || capture) begin
            rsp_valid <= 1'b1;
        end else if (rsp_fire) begin
            rsp_valid <= 1'b0;
        end
    end

    // Completed-response counter; wraps naturally at 2^CNTBITS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_count <= '0;
        end else if (rsp_fire) begin
            op_count <= op_count + CNT_ONE;
        end
    end

endmodule
